comp_save_mgr: RTL and testbench
================================

# comp_save_mgr

Downstream consumer of the per-thread computation buffer's second read port (data2). On a save request for a thread, it looks up that thread's save descriptor, then streams the eight 64-bit result words of the SHA-512 block into the thread's memory region. It writes only the first `save_len` words and discards the rest. When the block is fully consumed it signals completion per thread.

## Interface
Parameters:
- `N_THREADS`, 16: number of threads (min. 4).
- `N_THREADS_MSB`, `` `MSB(N_THREADS-1) ``: thread number MSB.
- `MEM_ADDR_MSB`, 7: memory word address MSB.

Ports:
- `CLK`, in, 1: the only clock.
- `reset`, in, 1: synchronous, active-high.
- `req_en`, in, 1: save request valid.
- `req_thread_num`, in, N_THREADS_MSB+1: thread to save.
- `req_rdy`, out, 1: request accepted when `req_en & req_rdy`.
- `rd_thread_num2`, out, N_THREADS_MSB+1: registered address to the computation buffer's data2 port.
- `comp_data2`, in, `` `COMP_DATA2_MSB ``+1: buffer `dout2`, valid 1 cycle after `rd_thread_num2` is registered.
- `din`, in, 64: result word from the core.
- `din_valid`, in, 1: `din` holds a word.
- `din_rd`, out, 1: combinational; a word is consumed on a cycle with `din_valid & din_rd`.
- `mem_wr_en`, out, 1: registered memory write strobe.
- `mem_wr_addr`, out, MEM_ADDR_MSB+1: registered write address.
- `mem_din`, out, 64: registered write data.
- `done_en`, out, 1: one-cycle completion pulse.
- `done_thread_num`, out, N_THREADS_MSB+1: thread that completed.

## Operation
- data2 fields, defined in `sha512.vh`:
  - `[3:0]` `save_len`: words to store, 0..8. Values above 8 clamp to 8.
  - `[4]` `save_en`: when 0, nothing is stored.
  - `[MEM_ADDR_MSB+5:5]` `save_addr`: base address.
- FSM states:
  - IDLE: `req_rdy=1`. On accept, latch the thread number into `rd_thread_num2`, then go to WAIT.
  - WAIT: one cycle for the buffer's registered read.
  - DECODE: latch `save_len` (clamped), `save_en` and `save_addr`; clear `word_cnt`; go to SAVE.
  - SAVE: `din_rd=1`.
    - Each consumed word increments the 3-bit `word_cnt`.
    - If `save_en` and `word_cnt < save_len`: `mem_wr_en<=1`, `mem_wr_addr<=save_addr+word_cnt` (modulo 2^(MEM_ADDR_MSB+1), wraps), `mem_din<=din`.
    - After the 8th word is consumed (`word_cnt==7`), go to DONE.
  - DONE: `done_en=1`, `done_thread_num` = the latched thread; go to IDLE.
- `din_rd=0` in every state except SAVE. Words presented outside SAVE are not consumed.
- A gap in `din_valid` during SAVE stalls the counter. There is no timeout.
- A request arriving while the FSM is not in IDLE is held off by `req_rdy=0`. Upstream keeps `req_en` asserted until accepted.

## Timing
- Request accepted at edge k:
  - `rd_thread_num2` is valid after k.
  - `comp_data2` is valid after k+1.
  - Fields are latched at k+2.
  - `din_rd` first asserts in the cycle after k+2.
- With continuous `din_valid`, SAVE lasts exactly 8 cycles.
- Write latency: a word consumed at edge j appears on `mem_wr_*` in the cycle after j, for one cycle.
- `done_en` asserts in the cycle after the 8th word's edge. It coincides with the final word's `mem_wr_en`, if that word is written.
- Back-to-back operation: IDLE is re-entered after DONE, so a new request is accepted one cycle after `done_en`. Minimum period per save is 12 cycles.
- Reset values: state IDLE, `req_rdy=1`, and all other outputs 0 (`rd_thread_num2`, `din_rd`, `mem_wr_en`, `mem_wr_addr`, `mem_din`, `done_en`, `done_thread_num`).
- Reset mid-operation aborts immediately: no further writes and no `done_en`. Upstream is reset alongside.

## Structure
- `sha512.vh` holds:
  - `` `COMP_DATA2_MSB ``
  - the field macros `` `COMP_SAVE_LEN ``, `` `COMP_SAVE_EN ``, `` `COMP_SAVE_ADDR ``
  - the block size constant `` `RESULT_WORDS `` (8)
- Single flat module. No sub-module is needed; the FSM, counter and output registers fit in one file.

## Test plan
- Thread 3, descriptor `save_en=1`, `save_len=8`, `save_addr=0x10`, 8 continuous words D0..D7 -> writes to 0x10..0x17 with D0..D7; `done_en` with thread 3 one cycle after the last consumed word.
- `save_len=3`, `save_addr=0x40` -> exactly 3 writes (0x40..0x42); all 8 words are consumed; `done_en` is asserted.
- `save_en=0` or `save_len=0` -> no `mem_wr_en`; 8 words consumed; `done_en` is asserted.
- `save_len=15` and `save_addr=0xFC` -> clamped to 8 writes at 0xFC,0xFD,0xFE,0xFF,0x00..0x03 (address wrap).
- `din_valid` toggling 1,0,1,0 -> one write per valid word; done only after 8 consumed.
  - A second request held during SAVE is accepted exactly one cycle after `done_en`.
- Reset asserted after the 4th word of a save -> outputs return to reset values next cycle; no `done_en`; a subsequent request completes normally.

Source files
------------

// File: rtl/comp_save_mgr_pkg.sv
// Shared definitions for the computation-result save manager: FSM states,
// descriptor field positions and the save-length clamp.
package comp_save_mgr_pkg;

  localparam int RESULT_WORDS  = 8;
  localparam int SAVE_LEN_LSB  = 0;
  localparam int SAVE_LEN_MSB  = 3;
  localparam int SAVE_EN_BIT   = 4;
  localparam int SAVE_ADDR_LSB = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_DECODE = 3'd2,
    ST_SAVE   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // A descriptor may ask for more words than a block holds; never store past the block.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len > 4'd8) begin
      return 4'd8;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/comp_save_mgr.sv
// Saves the eight 64-bit result words of a SHA-512 block into a thread's memory
// region, as described by the thread's descriptor on the buffer's data2 port.
module comp_save_mgr
  import comp_save_mgr_pkg::*;
#(
  parameter int N_THREADS     = 16,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
  parameter int MEM_ADDR_MSB  = 7
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      req_en,
  input  logic [N_THREADS_MSB:0]    req_thread_num,
  output logic                      req_rdy,
  output logic [N_THREADS_MSB:0]    rd_thread_num2,
  input  logic [MEM_ADDR_MSB+5:0]   comp_data2,
  input  logic [63:0]               din,
  input  logic                      din_valid,
  output logic                      din_rd,
  output logic                      mem_wr_en,
  output logic [MEM_ADDR_MSB:0]     mem_wr_addr,
  output logic [63:0]               mem_din,
  output logic                      done_en,
  output logic [N_THREADS_MSB:0]    done_thread_num
);

  localparam int AW = MEM_ADDR_MSB + 1;

  state_e                   state_q,   state_d;
  logic [N_THREADS_MSB:0]   thread_q,  thread_d;
  logic [3:0]               len_q,     len_d;
  logic                     en_q,      en_d;
  logic [MEM_ADDR_MSB:0]    base_q,    base_d;
  logic [2:0]               cnt_q,     cnt_d;
  logic                     wr_en_q,   wr_en_d;
  logic [MEM_ADDR_MSB:0]    wr_addr_q, wr_addr_d;
  logic [63:0]              wr_data_q, wr_data_d;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      thread_q  <= '0;
      len_q     <= 4'd0;
      en_q      <= 1'b0;
      base_q    <= '0;
      cnt_q     <= 3'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      thread_q  <= thread_d;
      len_q     <= len_d;
      en_q      <= en_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    thread_d        = thread_q;
    len_d           = len_q;
    en_d            = en_q;
    base_d          = base_q;
    cnt_d           = cnt_q;
    wr_en_d         = 1'b0;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;
    req_rdy         = 1'b0;
    din_rd          = 1'b0;
    done_en         = 1'b0;
    done_thread_num = '0;
    case (state_q)
      ST_IDLE: begin
        req_rdy = 1'b1;
        if (req_en) begin
          thread_d = req_thread_num;
          state_d  = ST_WAIT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        len_d   = clamp_len(comp_data2[SAVE_LEN_MSB:SAVE_LEN_LSB]);
        en_d    = comp_data2[SAVE_EN_BIT];
        base_d  = comp_data2[MEM_ADDR_MSB+SAVE_ADDR_LSB:SAVE_ADDR_LSB];
        cnt_d   = 3'd0;
        state_d = ST_SAVE;
      end
      ST_SAVE: begin
        din_rd = 1'b1;
        if (din_valid) begin
          cnt_d = cnt_q + 3'd1;
          // Words beyond save_len are still consumed, just not written.
          if (en_q && ({1'b0, cnt_q} < len_q)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q + AW'(cnt_q);
            wr_data_d = din;
          end else begin
            wr_en_d   = 1'b0;
          end
          if (cnt_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SAVE;
          end
        end else begin
          state_d = ST_SAVE;
        end
      end
      ST_DONE: begin
        done_en         = 1'b1;
        done_thread_num = thread_q;
        state_d         = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rd_thread_num2 = thread_q;
  assign mem_wr_en      = wr_en_q;
  assign mem_wr_addr    = wr_addr_q;
  assign mem_din        = wr_data_q;

endmodule

// File: tb/tb_comp_save_mgr.sv
// Directed bench for comp_save_mgr: descriptor-driven saves, clamping, address
// wrap, input stalls, held-off requests and mid-save reset.
module tb_comp_save_mgr;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_en;
  logic [3:0]  req_thread_num;
  logic        req_rdy;
  logic [3:0]  rd_thread_num2;
  logic [12:0] comp_data2;
  logic [63:0] din;
  logic        din_valid;
  logic        din_rd;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_addr;
  logic [63:0] mem_din;
  logic        done_en;
  logic [3:0]  done_thread_num;

  always #5 clk = ~clk;

  comp_save_mgr dut (
    .CLK            (clk),
    .reset          (reset),
    .req_en         (req_en),
    .req_thread_num (req_thread_num),
    .req_rdy        (req_rdy),
    .rd_thread_num2 (rd_thread_num2),
    .comp_data2     (comp_data2),
    .din            (din),
    .din_valid      (din_valid),
    .din_rd         (din_rd),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_addr    (mem_wr_addr),
    .mem_din        (mem_din),
    .done_en        (done_en),
    .done_thread_num(done_thread_num)
  );

  // Descriptor table: {save_addr[7:0], save_en, save_len[3:0]}, read with one cycle latency.
  logic [12:0] desc [16];
  always @(posedge clk) comp_data2 <= desc[rd_thread_num2];

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dw(input int i);
    return 64'hC0DE_0000_0000_0000 + 64'(i);
  endfunction

  logic [7:0]  wa [32];
  logic [63:0] wd [32];
  logic [3:0]  dthr [4];
  int done_c [4];
  int acc_c [4];
  int nwr, ndone, idx, acc_n, first_rd, last_cons, cons8;

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ctl"},
              {req_rdy, din_rd, mem_wr_en, done_en, rd_thread_num2, done_thread_num, mem_wr_addr},
              {1'b1, 3'b0, 4'h0, 4'h0, 8'h00});
    check_val({tag, "_din"}, mem_din, 64'd0);
  endtask

  task automatic run(input logic [3:0] thr, input bit tog, input bit has2,
                     input logic [3:0] thr2, input int abort_at);
    int pend;
    int ab;
    nwr = 0; ndone = 0; idx = 0; acc_n = 0;
    first_rd = -1; last_cons = -1; cons8 = -1;
    pend = has2 ? 2 : 1;
    ab = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 48; cyc++) begin
      if (mem_wr_en && nwr < 32) begin
        wa[nwr] = mem_wr_addr;
        wd[nwr] = mem_din;
        nwr++;
      end
      if (done_en && ndone < 4) begin
        dthr[ndone]   = done_thread_num;
        done_c[ndone] = cyc;
        ndone++;
      end
      if (din_rd && first_rd < 0) first_rd = cyc;
      if (ab == 1) begin
        check_reset_outputs("abort_rst");
        reset = 1'b0;
        ab = 2;
      end else if (ab == 0 && abort_at > 0 && idx == abort_at) begin
        reset = 1'b1;
        pend = 0;
        ab = 1;
      end
      if (pend > 0) begin
        req_en = 1'b1;
        req_thread_num = (acc_n == 0) ? thr : thr2;
      end else begin
        req_en = 1'b0;
      end
      if (req_en && req_rdy && !reset) begin
        acc_c[acc_n] = cyc;
        acc_n++;
        pend--;
      end
      din_valid = (ab != 0) ? 1'b0 : (tog ? (cyc % 2 == 0) : 1'b1);
      din = dw(idx);
      if (din_valid && din_rd) begin
        idx++;
        last_cons = cyc;
        if (idx == 8) cons8 = cyc;
      end
      @(negedge clk);
    end
    req_en = 1'b0;
    din_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_en = 1'b0; req_thread_num = 4'd0;
    din = 64'd0; din_valid = 1'b0;
    for (int i = 0; i < 16; i++) desc[i] = 13'd0;
    desc[3]  = {8'h10, 1'b1, 4'd8};
    desc[5]  = {8'h40, 1'b1, 4'd3};
    desc[6]  = {8'h50, 1'b0, 4'd8};
    desc[7]  = {8'h60, 1'b1, 4'd0};
    desc[9]  = {8'hFC, 1'b1, 4'd15};
    desc[10] = {8'h20, 1'b1, 4'd8};
    desc[11] = {8'h80, 1'b1, 4'd2};
    desc[12] = {8'h30, 1'b1, 4'd8};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Full save of thread 3.
    run(4'd3, 1'b0, 1'b0, 4'd0, 0);
    check_val("t3_nwr", 64'(nwr), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check_val("t3_addr", 64'(wa[i]), 64'(8'h10 + i));
      check_val("t3_data", wd[i], dw(i));
    end
    check_val("t3_cons", 64'(idx), 64'd8);
    check_val("t3_ndone", 64'(ndone), 64'd1);
    check_val("t3_dthr", 64'(dthr[0]), 64'd3);
    check_val("t3_done_lat", 64'(done_c[0]), 64'(last_cons + 1));
    check_val("t3_rd_lat", 64'(first_rd), 64'(acc_c[0] + 3));

    // Partial save, three words.
    run(4'd5, 1'b0, 1'b0, 4'd0, 0);
    check_val("len3_nwr", 64'(nwr), 64'd3);
    check_val("len3_a0", 64'(wa[0]), 64'h40);
    check_val("len3_a2", 64'(wa[2]), 64'h42);
    check_val("len3_d2", wd[2], dw(2));
    check_val("len3_cons", 64'(idx), 64'd8);
    check_val("len3_ndone", 64'(ndone), 64'd1);

    // Disabled save and zero-length save.
    run(4'd6, 1'b0, 1'b0, 4'd0, 0);
    check_val("en0_nwr", 64'(nwr), 64'd0);
    check_val("en0_cons", 64'(idx), 64'd8);
    check_val("en0_ndone", 64'(ndone), 64'd1);
    run(4'd7, 1'b0, 1'b0, 4'd0, 0);
    check_val("len0_nwr", 64'(nwr), 64'd0);
    check_val("len0_cons", 64'(idx), 64'd8);
    check_val("len0_ndone", 64'(ndone), 64'd1);

    // Length 15 clamps to 8; base 0xFC wraps past 0xFF.
    run(4'd9, 1'b0, 1'b0, 4'd0, 0);
    check_val("clamp_nwr", 64'(nwr), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check_val("wrap_addr", 64'(wa[i]), 64'((8'hFC + i) % 256));
    end
    check_val("clamp_ndone", 64'(ndone), 64'd1);

    // Stalled input stream, with a second request held off until after done.
    run(4'd10, 1'b1, 1'b1, 4'd11, 0);
    check_val("tog_nwr", 64'(nwr), 64'd10);
    check_val("tog_d7", wd[7], dw(7));
    check_val("tog_a7", 64'(wa[7]), 64'h27);
    check_val("tog_done_lat", 64'(done_c[0]), 64'(cons8 + 1));
    check_val("tog_ndone", 64'(ndone), 64'd2);
    check_val("tog_dthr0", 64'(dthr[0]), 64'd10);
    check_val("tog_dthr1", 64'(dthr[1]), 64'd11);
    check_val("held_acc", 64'(acc_c[1]), 64'(done_c[0] + 1));
    check_val("held_a8", 64'(wa[8]), 64'h80);
    check_val("held_a9", 64'(wa[9]), 64'h81);
    check_val("held_d9", wd[9], dw(9));
    check_val("tog_cons", 64'(idx), 64'd16);

    // Reset after the fourth word, then a normal save.
    run(4'd12, 1'b0, 1'b0, 4'd0, 4);
    check_val("abort_nwr", 64'(nwr), 64'd4);
    check_val("abort_a3", 64'(wa[3]), 64'h33);
    check_val("abort_ndone", 64'(ndone), 64'd0);
    run(4'd3, 1'b0, 1'b0, 4'd0, 0);
    check_val("post_nwr", 64'(nwr), 64'd8);
    check_val("post_a7", 64'(wa[7]), 64'h17);
    check_val("post_d7", wd[7], dw(7));
    check_val("post_ndone", 64'(ndone), 64'd1);
    check_val("post_dthr", 64'(dthr[0]), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
